// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-beat output slot.
// Define RR_ARBITER_LOCK_EN to enable burst locking (ARB/LOCKED FSM).
module rr_arbiter #(
  parameter int REQ  = 4,
  parameter int DATA = 8,
  parameter int ID_W = $clog2(REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQ-1:0]            req,
  input  logic [REQ-1:0][DATA-1:0]  in,
  input  logic [REQ-1:0]            lock,
  output logic [REQ-1:0]            grant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA-1:0]           out_data,
  output logic [ID_W-1:0]           out_id
);

  localparam logic [ID_W:0]   REQ_CNT = (ID_W+1)'(REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(REQ - 1);

  logic                 out_valid_reg;
  logic [DATA-1:0]      out_data_reg;
  logic [ID_W-1:0]      out_id_reg;
  logic [ID_W-1:0]      ptr_reg;
  logic [ID_W-1:0]      ptr_next;

  logic [REQ-1:0]       lock_mask;
  logic [REQ-1:0]       eff_req;
  logic [REQ-1:0]       rot_req;
  logic [2*REQ-1:0]     dbl_req;
  logic [ID_W-1:0]      rot_off;
  logic [ID_W:0]        gnt_sum;
  logic [ID_W-1:0]      gnt_id;
  logic                 slot_open;
  logic                 grant_any;

  assign slot_open = !out_valid_reg || out_ready;

`ifdef RR_ARBITER_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] lk_id_reg, lk_id_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ARB;
      lk_id_reg <= '0;
    end else begin
      state_reg <= state_next;
      lk_id_reg <= lk_id_next;
    end
  end

  // The lock bit travels with the beat: it is sampled only on a granted cycle.
  always_comb begin
    state_next = state_reg;
    lk_id_next = lk_id_reg;
    case (state_reg)
      ARB: begin
        if (grant_any && lock[gnt_id]) begin
          state_next = LOCKED;
          lk_id_next = gnt_id;
        end
      end
      LOCKED: begin
        if (grant_any && !lock[gnt_id]) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  for (genvar gi = 0; gi < REQ; gi++) begin : g_lock_mask
    assign lock_mask[gi] = (state_reg != LOCKED) || (lk_id_reg == ID_W'(gi));
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_mask   = '1;
`endif

  for (genvar gi = 0; gi < REQ; gi++) begin : g_eff_req
    assign eff_req[gi] = req[gi] & lock_mask[gi];
  end

  // Rotate so that bit 0 of rot_req corresponds to requester ptr_reg.
  assign dbl_req = {eff_req, eff_req};
  assign rot_req = REQ'(dbl_req >> ptr_reg);

  always_comb begin
    rot_off = '0;
    for (int k = REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) rot_off = ID_W'(k);
    end
  end

  assign gnt_sum   = {1'b0, ptr_reg} + {1'b0, rot_off};
  assign gnt_id    = (gnt_sum >= REQ_CNT) ? ID_W'(gnt_sum - REQ_CNT) : gnt_sum[ID_W-1:0];
  assign grant_any = slot_open && !reset && (|eff_req);
  assign ptr_next  = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);

  for (genvar gi = 0; gi < REQ; gi++) begin : g_grant
    assign grant[gi] = grant_any && (gnt_id == ID_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      ptr_reg       <= '0;
    end else if (grant_any) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in[gnt_id];
      out_id_reg    <= gnt_id;
      ptr_reg       <= ptr_next;
    end else if (slot_open) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;

endmodule
